mmu_seq_ctrl: RTL
=================

// Module: mmu_seq_ctrl
// PURPOSE
//  Sequencer for the 4x4 weight-stationary systolic MMU in the convolution layer.
//  - Runs one tile job per start: loads DEPTH weight rows (mmu_control=1), then streams
//    num_rows input rows (mmu_control=0) with per-lane input skew.
//  - Drains the array, then tags each accumulator lane with a result-valid strobe.
//  - Sits between the conv-layer buffer/fetch logic and the MMU instance.
// PARAMETERS
//  DEPTH      4   array dimension (lanes per row)
//  BIT_WIDTH  8   width of each data/weight element
//  ROWS_W     16  width of the num_rows job field
//  MMU_LAT    8   cycles from a lane-0 element on mmu_data_arr to its lane-0 sum on MMU acc_out
// PORTS
//  clk           in   1                 clock, rising edge
//  rst_n         in   1                 asynchronous, active-low reset
//  start         in   1                 job start pulse; sampled only in IDLE
//  num_rows      in   ROWS_W            input rows in the job; sampled with start
//  busy          out  1                 high from the cycle after accepted start until DONE
//  done          out  1                 one-cycle pulse at job end
//  wt_valid      in   1                 weight row valid
//  wt_ready      out  1                 weight row accepted when wt_valid & wt_ready
//  wt_row        in   DEPTH*BIT_WIDTH   weight row; lane k in bits [8k+7:8k]
//  in_valid      in   1                 input row valid
//  in_ready      out  1                 input row accepted when in_valid & in_ready
//  in_row        in   DEPTH*BIT_WIDTH   input row; lane k in bits [8k+7:8k]
//  mmu_control   out  1                 to MMU control: 1 = weight load, 0 = compute
//  mmu_wt_arr    out  DEPTH*BIT_WIDTH   to MMU wt_arr
//  mmu_data_arr  out  DEPTH*BIT_WIDTH   to MMU data_arr, skewed
//  res_valid     out  DEPTH             bit k high: MMU acc_out lane k holds a real result
// BEHAVIOUR
//  Reset and outputs
//  - All outputs, state, counters and skew/valid shift registers are 0; FSM is in IDLE.
//  - Reset mid-job aborts the job immediately; no done is generated.
//  FSM states: IDLE -> LOAD_WT -> STREAM -> DRAIN -> DONE -> IDLE
//  - IDLE: start=1 latches num_rows and enters LOAD_WT. start in any other state is ignored.
//  - LOAD_WT:
//    - mmu_control=1; wt_ready=1.
//    - Each accepted wt_row drives mmu_wt_arr registered, one cycle after acceptance.
//    - When wt_valid=0, mmu_wt_arr=0 and the weight counter holds.
//    - Rows are forwarded in arrival order; the producer sends the bottom array row first.
//    - After DEPTH accepted rows: go to STREAM, or to DRAIN if num_rows==0.
//  - STREAM:
//    - mmu_control=0; in_ready=1 while rows remain.
//    - An accepted row at cycle t puts lane k on mmu_data_arr at cycle t+1+k (k-stage skew regs).
//    - Any lane with no accepted element in its slot carries 0; stalls insert zero bubbles.
//    - After num_rows accepted rows, in_ready drops the same cycle; go to DRAIN.
//  - DRAIN: mmu_control=0 for DEPTH-1+MMU_LAT+DEPTH cycles (counter), flushing skew and array.
//  - DONE: done=1 for one cycle; busy=0 next cycle; back to IDLE.
//  Result strobes
//  - A row accepted at t asserts res_valid[k] at exactly t+1+MMU_LAT+k, for one cycle per row.
//  - Implemented as valid shift registers; bubbles produce no strobe.
//  Rules
//  - wt_ready=0 outside LOAD_WT; in_ready=0 outside STREAM.
//  - mmu_control is held constant for the whole of each phase.
//  - Skew registers reset to 0 when entering LOAD_WT, so no stale data reaches the array.
//  - num_rows = 2^ROWS_W-1 must complete without counter wrap; the row counter is ROWS_W bits.
// TESTING
//  - Reset: rst_n=0 mid-STREAM -> all outputs 0 next edge. Release, start again -> full job completes.
//  - Basic job: W=identity, num_rows=4, rows {1,2,3,4}x4, no stalls.
//    -> res_valid[k] strobes at t+9+k; MMU lane k sums equal the input rows.
//    -> done exactly 1 cycle after the drain count expires.
//  - Stalls: wt_valid low 2 cycles mid-load; in_valid alternating 1/0 with num_rows=3.
//    -> mmu_control stays 1 through the load; zero bubbles are inserted.
//    -> exactly 3 strobes per lane; sums are unchanged vs. the no-stall case.
//  - num_rows=0: LOAD_WT -> DRAIN -> DONE; no in_ready, no res_valid, done pulses once.
//  - start held high through a whole job -> exactly one job runs; start is re-accepted only in IDLE.
//  - Back-to-back: start the cycle after done, new weights
//    -> no first-job data or strobes leak into the second job.

Source files
------------

// File: rtl/mmu_seq_ctrl_if.sv
// mmu_seq_ctrl_if: job, weight/input handshake and MMU drive bundle for the systolic sequencer.
interface mmu_seq_ctrl_if #(
    parameter int DEPTH     = 4,
    parameter int BIT_WIDTH = 8,
    parameter int ROWS_W    = 16
);
    logic                       start;
    logic [ROWS_W-1:0]          num_rows;
    logic                       busy;
    logic                       done;
    logic                       wt_valid;
    logic                       wt_ready;
    logic [DEPTH*BIT_WIDTH-1:0] wt_row;
    logic                       in_valid;
    logic                       in_ready;
    logic [DEPTH*BIT_WIDTH-1:0] in_row;
    logic                       mmu_control;
    logic [DEPTH*BIT_WIDTH-1:0] mmu_wt_arr;
    logic [DEPTH*BIT_WIDTH-1:0] mmu_data_arr;
    logic [DEPTH-1:0]           res_valid;

    modport slave (
        input  start, num_rows, wt_valid, wt_row, in_valid, in_row,
        output busy, done, wt_ready, in_ready, mmu_control, mmu_wt_arr, mmu_data_arr, res_valid
    );

    modport master (
        output start, num_rows, wt_valid, wt_row, in_valid, in_row,
        input  busy, done, wt_ready, in_ready, mmu_control, mmu_wt_arr, mmu_data_arr, res_valid
    );
endinterface

// File: rtl/mmu_seq_ctrl.sv
// mmu_seq_ctrl: per-job weight load, skewed input streaming, drain and result strobes for a systolic MMU.
module mmu_seq_ctrl #(
    parameter int DEPTH     = 4,
    parameter int BIT_WIDTH = 8,
    parameter int ROWS_W    = 16,
    parameter int MMU_LAT   = 8
) (
    input logic           clk,
    input logic           rst_n,
    mmu_seq_ctrl_if.slave bus
);
    localparam int DRAIN_CYC = 2*DEPTH - 1 + MMU_LAT;
    localparam int CW        = $clog2(DRAIN_CYC + 1);
    localparam int VL        = MMU_LAT + DEPTH;
    localparam logic [CW-1:0] WT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DR_LAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD_WT, STREAM, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [ROWS_W-1:0]          rows_q, rows_d;
    logic [DEPTH*BIT_WIDTH-1:0] wt_q;
    logic [DEPTH*BIT_WIDTH-1:0] data_arr;
    logic [VL-1:0]              v_q;
    logic                       wt_acc, in_acc, clr;

    assign wt_acc = (state_q == LOAD_WT) && bus.wt_valid;
    assign in_acc = (state_q == STREAM) && bus.in_valid;
    assign clr    = (state_q == IDLE) && bus.start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = LOAD_WT;
                rows_d  = bus.num_rows;
                cnt_d   = '0;
            end
            LOAD_WT: if (wt_acc) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WT_LAST) begin
                    cnt_d   = '0;
                    state_d = (rows_q == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: if (in_acc) begin
                rows_d  = rows_q - 1'b1;
                state_d = (rows_q == ROWS_W'(1)) ? DRAIN : STREAM;
            end
            DRAIN: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == DR_LAST) ? DONE : DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
            wt_q    <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            wt_q    <= wt_acc ? bus.wt_row : '0;
            v_q     <= clr ? '0 : {v_q[VL-2:0], in_acc};
        end
    end

    // lane k gets k+1 register stages so the array sees a diagonal wavefront
    for (genvar k = 0; k < DEPTH; k++) begin : g_lane
        logic [BIT_WIDTH-1:0] sr_q [k+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '{default: '0};
            end else if (clr) begin
                sr_q <= '{default: '0};
            end else begin
                sr_q[0] <= in_acc ? bus.in_row[k*BIT_WIDTH +: BIT_WIDTH] : '0;
                for (int j = 1; j <= k; j++) sr_q[j] <= sr_q[j-1];
            end
        end
        assign data_arr[k*BIT_WIDTH +: BIT_WIDTH] = sr_q[k];
    end

    assign bus.busy         = state_q != IDLE;
    assign bus.done         = state_q == DONE;
    assign bus.wt_ready     = state_q == LOAD_WT;
    assign bus.in_ready     = state_q == STREAM;
    assign bus.mmu_control  = state_q == LOAD_WT;
    assign bus.mmu_wt_arr   = wt_q;
    assign bus.mmu_data_arr = data_arr;
    assign bus.res_valid    = v_q[VL-1:MMU_LAT];
endmodule
